frame_ram_arbiter: RTL

Single-clock arbiter sharing the frame PSRAM command port between two requesters: the video scan-out read path (burst reads for the next pixel group) and the UART control write path (single-word host writes).
- Host writes are buffered in a small FIFO and drained opportunistically, or preferentially during blanking.
- Removes any need to switch the RAM clock between domains.
- Sits between the control decoder, the video controller and the ram wrapper.

---
 rtl/frame_arb_pkg.sv | 25 ++
 rtl/arb_wfifo.sv | 80 ++++++++
 rtl/frame_ram_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_arb_pkg.sv
// ----------------------------------------------------------------------------
// frame_arb_pkg
//   Shared types and default widths for the frame PSRAM command-port arbiter.
//   - arb_state_e   : arbiter FSM states
//   - wfifo_entry_t : host write FIFO entry {addr, data} at default widths
//   - DEF_ADDR_W / DEF_DATA_W : default RAM word-address and data widths
// ----------------------------------------------------------------------------
package frame_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 22;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      VID_ISSUE = 2'd1,
      VID_DRAIN = 2'd2,
      HOST_WR   = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wfifo_entry_t;

endpackage

// File: rtl/arb_wfifo.sv
// ----------------------------------------------------------------------------
// arb_wfifo
//   Synchronous FIFO buffering host writes until the arbiter can issue them.
//   A push while full is dropped (FIFO state unchanged) and flagged on
//   drop_o for one cycle. Push and pop in the same cycle are both honoured.
//
//   Parameters : DEPTH   entries (power of 2, >= 2)
//                entry_t stored element type
//   Ports      : clk_i, rst_i (async, active-high)
//                push_i / push_data_i  write side
//                pop_i  / head_o       read side (head_o valid when !empty_o)
//                empty_o               combinational, count == 0
//                full_o                registered, count == DEPTH
//                drop_o                push attempted while full
// ----------------------------------------------------------------------------
module arb_wfifo
   import frame_arb_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = wfifo_entry_t
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   push_i,
   input  entry_t push_data_i,
   input  logic   pop_i,
   output entry_t head_o,
   output logic   empty_o,
   output logic   full_o,
   output logic   drop_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   count_q;
   logic [PW:0]   count_d;
   logic          full_q;
   logic          push_ok;
   logic          pop_ok;

   assign push_ok = push_i && !full_q;
   assign pop_ok  = pop_i && (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == (PW+1)'(DEPTH));
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = full_q;
   assign drop_o  = push_i && full_q;

endmodule

// File: rtl/frame_ram_arbiter.sv
// ----------------------------------------------------------------------------
// frame_ram_arbiter
//   Shares the frame PSRAM command port between video scan-out burst reads
//   and buffered single-word host writes, all in one clock domain.
//
//   Optional feature (macro ARB_OVF_CNT_EN): O_ovf_cnt counts dropped host
//   writes, saturating at 255, cleared only by reset. Without the macro
//   O_ovf_cnt is tied to 0.
//
//   Ports:
//     I_clk, I_rst                  clock, async active-high reset
//     I_blanking                    host writes take priority while high
//     I_vid_req/I_vid_addr/O_vid_gnt  video burst request/address/grant pulse
//     O_vid_rdata/O_vid_rvalid      read data returned to video (1-cycle lat)
//     I_host_wr/addr/data, O_host_full  host write FIFO side
//     O_ram_cmd/we/addr/wdata, I_ram_ready  RAM command (held until ready)
//     I_ram_rdata/I_ram_rvalid      RAM read return
//     O_ovf_cnt                     dropped-write count
// ----------------------------------------------------------------------------
module frame_ram_arbiter
   import frame_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned WFIFO_DEPTH = 4
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_blanking,
   input  logic              I_vid_req,
   input  logic [ADDR_W-1:0] I_vid_addr,
   output logic              O_vid_gnt,
   output logic [DATA_W-1:0] O_vid_rdata,
   output logic              O_vid_rvalid,
   input  logic              I_host_wr,
   input  logic [ADDR_W-1:0] I_host_addr,
   input  logic [DATA_W-1:0] I_host_data,
   output logic              O_host_full,
   output logic              O_ram_cmd,
   output logic              O_ram_we,
   output logic [ADDR_W-1:0] O_ram_addr,
   output logic [DATA_W-1:0] O_ram_wdata,
   input  logic              I_ram_ready,
   input  logic [DATA_W-1:0] I_ram_rdata,
   input  logic              I_ram_rvalid,
   output logic [7:0]        O_ovf_cnt
);

   localparam int unsigned   CW        = $clog2(BURST_LEN) + 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t     push_entry;
   entry_t     fifo_head;
   logic       fifo_empty;
   logic       fifo_full;
   logic       fifo_drop;
   logic       fifo_pop;

   arb_state_e        state_q;
   logic [ADDR_W-1:0] base_q;
   logic [CW-1:0]     issue_q;
   logic [CW-1:0]     outst_q;
   logic [CW-1:0]     outst_d;
   logic              cmd_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              gnt_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q;
   logic              last_host_q;

   logic handshake;
   logic rd_hs;
   logic ret_ok;
   logic host_first;
   logic host_sel;

   assign push_entry = '{addr: I_host_addr, data: I_host_data};

   arb_wfifo #(
      .DEPTH   (WFIFO_DEPTH),
      .entry_t (entry_t)
   ) u_wfifo (
      .clk_i       (I_clk),
      .rst_i       (I_rst),
      .push_i      (I_host_wr),
      .push_data_i (push_entry),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .drop_o      (fifo_drop)
   );

   assign handshake = cmd_q && I_ram_ready;
   assign rd_hs     = handshake && !we_q;
   assign ret_ok    = I_ram_rvalid && (outst_q != '0);
   assign fifo_pop  = (state_q == HOST_WR) && handshake;

   // Blanking priority yields once to a waiting video request after a host
   // write, so blanking with a busy FIFO still interleaves write/burst/write.
   assign host_first = !fifo_empty && I_blanking && !(last_host_q && I_vid_req);
   assign host_sel   = host_first || (!I_vid_req && !fifo_empty);

   always_comb begin
      outst_d = outst_q;
      if (rd_hs && !ret_ok) begin
         outst_d = outst_q + 1'b1;
      end else if (!rd_hs && ret_ok) begin
         outst_d = outst_q - 1'b1;
      end
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         issue_q     <= '0;
         outst_q     <= '0;
         cmd_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         gnt_q       <= 1'b0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         last_host_q <= 1'b0;
      end else begin
         gnt_q    <= 1'b0;
         outst_q  <= outst_d;
         rvalid_q <= ret_ok;
         if (ret_ok) rdata_q <= I_ram_rdata;

         case (state_q)
            IDLE: begin
               if (host_sel) begin
                  state_q <= HOST_WR;
                  cmd_q   <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= fifo_head.addr;
                  wdata_q <= fifo_head.data;
               end else if (I_vid_req) begin
                  state_q     <= VID_ISSUE;
                  gnt_q       <= 1'b1;
                  base_q      <= I_vid_addr;
                  issue_q     <= '0;
                  cmd_q       <= 1'b1;
                  we_q        <= 1'b0;
                  addr_q      <= I_vid_addr;
                  last_host_q <= 1'b0;
               end
            end
            VID_ISSUE: begin
               if (handshake) begin
                  if (issue_q == LAST_BEAT) begin
                     cmd_q   <= 1'b0;
                     state_q <= VID_DRAIN;
                  end else begin
                     issue_q <= issue_q + 1'b1;
                     addr_q  <= base_q + ADDR_W'(issue_q + 1'b1);
                  end
               end
            end
            VID_DRAIN: begin
               if (outst_q == '0) state_q <= IDLE;
            end
            HOST_WR: begin
               if (handshake) begin
                  cmd_q       <= 1'b0;
                  we_q        <= 1'b0;
                  state_q     <= IDLE;
                  last_host_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign O_vid_gnt    = gnt_q;
   assign O_vid_rdata  = rdata_q;
   assign O_vid_rvalid = rvalid_q;
   assign O_host_full  = fifo_full;
   assign O_ram_cmd    = cmd_q;
   assign O_ram_we     = we_q;
   assign O_ram_addr   = addr_q;
   assign O_ram_wdata  = wdata_q;

`ifdef ARB_OVF_CNT_EN
   logic [7:0] ovf_q;

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         ovf_q <= '0;
      end else if (fifo_drop && (ovf_q != '1)) begin
         ovf_q <= ovf_q + 1'b1;
      end
   end

   assign O_ovf_cnt = ovf_q;
`else
   logic unused_drop;
   assign unused_drop = fifo_drop;
   assign O_ovf_cnt   = '0;
`endif

endmodule
